decode_stage: RTL and testbench
===============================

# decode_stage

Instruction-decode stage of the five-stage MIPS pipeline, directly downstream of the fetch stage. It latches the fetched instruction, control bundle and sequential PC into the IF/ID pipeline register. It reads the 32×32 register file, extends the immediate and detects load-use hazards, producing a stall back to fetch. Taken jumps/branches flush it to a NOP bubble.

## Interface
- RESET_PC, 32'h00400000, pc_seq_out value held after reset
- NOP_INSTR, 32'h34000000, bubble instruction (ori $zero,$zero,0)
- NOP_BUNDLE, 24'h0E2531, control bundle paired with NOP_INSTR

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- instruction_in  in  32  instruction from fetch
- bundle_in  in  24  control bundle from fetch
- pc_seq_in  in  32  PC+4 from fetch
- jump_branch_in  in  1  taken jump/branch; flush IF/ID
- wb_en_in  in  1  register-file write enable (writeback)
- wb_addr_in  in  5  write register number
- wb_data_in  in  32  write data
- ex_mem_read_in  in  1  instruction in EX is a load
- ex_rt_in  in  5  destination register of that load
- stall_out  out  1  load-use hazard; fetch must hold
- instruction_out  out  32  IF/ID instruction, or NOP_INSTR when bubbling
- bundle_out  out  24  IF/ID bundle, or NOP_BUNDLE when bubbling
- pc_seq_out  out  32  IF/ID PC+4
- valid_out  out  1  instruction_out is a real instruction
- rs_out / rt_out / rd_out  out  5 each  fields [25:21], [20:16], [15:11] of held instruction
- rs_data_out / rt_data_out  out  32  register-file read data
- imm_ext_out  out  32  extended immediate

## Operation
- IF/ID register fields: instr, bundle, pc_seq, valid. Updates on each rising clk edge by priority:
  1. jump_branch_in=1: load NOP_INSTR, NOP_BUNDLE, valid=0. pc_seq takes pc_seq_in.
  2. stall_out=1: hold all fields.
  3. otherwise: load the inputs, valid=1.
- Flush beats stall when both occur in the same cycle.
- stall_out = ex_mem_read_in & (ex_rt_in≠0) & valid & (ex_rt_in==rs_out | ex_rt_in==rt_out). This is combinational from the held IF/ID fields and EX inputs.
- While stall_out=1, instruction_out/bundle_out present NOP_INSTR/NOP_BUNDLE and valid_out=0. This inserts one bubble into EX. rs/rt/rd/data outputs still reflect the held instruction.
- Register file: 32 entries × 32 bits. Register 0 reads 0 and ignores writes. A write occurs on the clk edge when wb_en_in=1 and wb_addr_in≠0.
- Reads are combinational on rs_out/rt_out.
- Immediate (imm = instr[15:0], op = instr[31:26]):
  - op 0x0C/0x0D/0x0E (andi/ori/xori): zero-extend.
  - op 0x0F (lui): {imm,16'h0}.
  - All other opcodes: sign-extend.

## Timing
- Latency: instruction_in to instruction_out is 1 cycle.
- Register-file write is visible on the read ports per the Configuration section.
- Reset (asynchronous, any time, including mid-stall):
  - IF/ID becomes NOP_INSTR / NOP_BUNDLE / RESET_PC / valid=0.
  - All 32 registers clear to 0.
  - Resulting outputs: instruction_out=0x34000000, bundle_out=0x0E2531, pc_seq_out=0x00400000, valid_out=0, stall_out=0, rs/rt/rd=0, rs_data/rt_data=0, imm_ext_out=0.
- Stall lasts exactly 1 cycle per load-use hazard: the next cycle EX holds the bubble, so ex_mem_read_in drops.

## Configuration
- DECODE_BYPASS_EN defined: write-through bypass. When wb_en_in=1, wb_addr_in≠0 and wb_addr_in equals the read address, the read port returns wb_data_in in the same cycle.
- DECODE_BYPASS_EN undefined: reads return the stored value. New data appears the cycle after the write edge.

## Test plan
- Reset release, no writes, fetch supplies ori $1,$0,0x8001 (0x34018001), pc_seq 0x00400004 → after 1 edge: instruction_out=0x34018001, valid_out=1, imm_ext_out=0x00008001, pc_seq_out=0x00400004.
- addi with imm 0xFFF0 → imm_ext_out=0xFFFFFFF0. lui imm 0x1234 → 0x12340000.
- Write $5=0xDEADBEEF, then decode an instruction with rs=5:
  - DECODE_BYPASS_EN defined: same-cycle read gives 0xDEADBEEF.
  - DECODE_BYPASS_EN undefined: same-cycle read gives 0; the next cycle gives 0xDEADBEEF.
  - Write to $0 with 0xFFFFFFFF → reads 0.
- Held add $3,$2,$4 with ex_mem_read_in=1, ex_rt_in=4 → stall_out=1, instruction_out=0x34000000, valid_out=0, IF/ID unchanged after the edge. Drop ex_mem_read_in → add issues, valid_out=1.
- Stall and jump_branch_in both high on the same edge → IF/ID becomes the NOP with valid_out=0. Reset asserted mid-stall → all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: IF/ID pipeline register, 32x32 register file, immediate
// extension and load-use hazard detection for the MIPS decode stage.
// Optional feature: define DECODE_BYPASS_EN for a write-through read bypass
// (writeback data visible on the read ports in the same cycle as the write).
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction_in,
    input  logic [23:0] bundle_in,
    input  logic [31:0] pc_seq_in,
    input  logic        jump_branch_in,
    input  logic        wb_en_in,
    input  logic [4:0]  wb_addr_in,
    input  logic [31:0] wb_data_in,
    input  logic        ex_mem_read_in,
    input  logic [4:0]  ex_rt_in,
    output logic        stall_out,
    output logic [31:0] instruction_out,
    output logic [23:0] bundle_out,
    output logic [31:0] pc_seq_out,
    output logic        valid_out,
    output logic [4:0]  rs_out,
    output logic [4:0]  rt_out,
    output logic [4:0]  rd_out,
    output logic [31:0] rs_data_out,
    output logic [31:0] rt_data_out,
    output logic [31:0] imm_ext_out
);

    localparam logic [31:0] RESET_PC   = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR  = 32'h3400_0000;
    localparam logic [23:0] NOP_BUNDLE = 24'h0E_2531;

    // IF/ID pipeline register
    logic [31:0] instr_q, instr_d;
    logic [23:0] bundle_q, bundle_d;
    logic [31:0] pc_seq_q, pc_seq_d;
    logic        valid_q, valid_d;

    // Register file
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    logic        stall;
    logic        wb_write;

    assign rs_out   = instr_q[25:21];
    assign rt_out   = instr_q[20:16];
    assign rd_out   = instr_q[15:11];
    assign wb_write = wb_en_in && (wb_addr_in != 5'd0);

    // Load-use hazard: the load in EX targets a source of the held instruction
    always_comb begin
        stall = ex_mem_read_in && (ex_rt_in != 5'd0) && valid_q &&
                ((ex_rt_in == rs_out) || (ex_rt_in == rt_out));
    end

    // IF/ID next state: flush has priority over stall, stall holds
    always_comb begin
        instr_d  = instr_q;
        bundle_d = bundle_q;
        pc_seq_d = pc_seq_q;
        valid_d  = valid_q;
        if (jump_branch_in) begin
            instr_d  = NOP_INSTR;
            bundle_d = NOP_BUNDLE;
            pc_seq_d = pc_seq_in;
            valid_d  = 1'b0;
        end else if (!stall) begin
            instr_d  = instruction_in;
            bundle_d = bundle_in;
            pc_seq_d = pc_seq_in;
            valid_d  = 1'b1;
        end
    end

    // IF/ID register with asynchronous reset to the NOP bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q  <= NOP_INSTR;
            bundle_q <= NOP_BUNDLE;
            pc_seq_q <= RESET_PC;
            valid_q  <= 1'b0;
        end else begin
            instr_q  <= instr_d;
            bundle_q <= bundle_d;
            pc_seq_q <= pc_seq_d;
            valid_q  <= valid_d;
        end
    end

    // Register file next state: single write port, $0 never written
    always_comb begin
        regs_d = regs_q;
        if (wb_write) begin
            regs_d[wb_addr_in] = wb_data_in;
        end
    end

    // Register file storage, cleared by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Combinational read ports, optionally bypassing the pending write
    always_comb begin
        rs_data_out = (rs_out == 5'd0) ? '0 : regs_q[rs_out];
        rt_data_out = (rt_out == 5'd0) ? '0 : regs_q[rt_out];
`ifdef DECODE_BYPASS_EN
        if (wb_write && (wb_addr_in == rs_out)) begin
            rs_data_out = wb_data_in;
        end
        if (wb_write && (wb_addr_in == rt_out)) begin
            rt_data_out = wb_data_in;
        end
`endif
    end

    // Immediate extension: logical ops zero-extend, lui shifts, rest sign-extend
    always_comb begin
        case (instr_q[31:26])
            6'h0C, 6'h0D, 6'h0E: imm_ext_out = {16'h0000, instr_q[15:0]};
            6'h0F:               imm_ext_out = {instr_q[15:0], 16'h0000};
            default:             imm_ext_out = {{16{instr_q[15]}}, instr_q[15:0]};
        endcase
    end

    // Stalled instruction is replaced by a bubble toward EX
    always_comb begin
        stall_out       = stall;
        instruction_out = stall ? NOP_INSTR : instr_q;
        bundle_out      = stall ? NOP_BUNDLE : bundle_q;
        pc_seq_out      = pc_seq_q;
        valid_out       = valid_q && !stall;
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed literal cases plus a
// randomized run compared every cycle against a behavioural model.
module tb_decode_stage;

    localparam logic [31:0] RESET_PC   = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR  = 32'h3400_0000;
    localparam logic [23:0] NOP_BUNDLE = 24'h0E_2531;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction_in;
    logic [23:0] bundle_in;
    logic [31:0] pc_seq_in;
    logic        jump_branch_in;
    logic        wb_en_in;
    logic [4:0]  wb_addr_in;
    logic [31:0] wb_data_in;
    logic        ex_mem_read_in;
    logic [4:0]  ex_rt_in;
    logic        stall_out;
    logic [31:0] instruction_out;
    logic [23:0] bundle_out;
    logic [31:0] pc_seq_out;
    logic        valid_out;
    logic [4:0]  rs_out, rt_out, rd_out;
    logic [31:0] rs_data_out, rt_data_out, imm_ext_out;

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 1'b0;

    decode_stage dut (
        .clk             (clk),
        .reset           (reset),
        .instruction_in  (instruction_in),
        .bundle_in       (bundle_in),
        .pc_seq_in       (pc_seq_in),
        .jump_branch_in  (jump_branch_in),
        .wb_en_in        (wb_en_in),
        .wb_addr_in      (wb_addr_in),
        .wb_data_in      (wb_data_in),
        .ex_mem_read_in  (ex_mem_read_in),
        .ex_rt_in        (ex_rt_in),
        .stall_out       (stall_out),
        .instruction_out (instruction_out),
        .bundle_out      (bundle_out),
        .pc_seq_out      (pc_seq_out),
        .valid_out       (valid_out),
        .rs_out          (rs_out),
        .rt_out          (rt_out),
        .rd_out          (rd_out),
        .rs_data_out     (rs_data_out),
        .rt_data_out     (rt_data_out),
        .imm_ext_out     (imm_ext_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_instr;
    logic [23:0] m_bundle;
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_regs [32];

    function automatic bit m_hazard();
        logic [4:0] s, t;
        s = m_instr[25:21];
        t = m_instr[20:16];
        return ex_mem_read_in && ex_rt_in != 0 && m_valid && (ex_rt_in == s || ex_rt_in == t);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'd0;
`ifdef DECODE_BYPASS_EN
        if (wb_en_in && wb_addr_in == a) return wb_data_in;
`endif
        return m_regs[a];
    endfunction

    function automatic logic [31:0] m_imm(input logic [31:0] ins);
        int unsigned op;
        int v;
        op = ins[31:26];
        if (op >= 12 && op <= 14) return 32'(ins[15:0]);
        if (op == 15) return 32'(ins[15:0]) * 32'd65536;
        v = int'(ins[15:0]);
        if (v >= 32768) v = v - 65536;
        return 32'(v);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_instr  <= NOP_INSTR;
            m_bundle <= NOP_BUNDLE;
            m_pc     <= RESET_PC;
            m_valid  <= 1'b0;
            for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
        end else begin
            if (wb_en_in && wb_addr_in != 0) m_regs[wb_addr_in] <= wb_data_in;
            if (jump_branch_in) begin
                m_instr  <= NOP_INSTR;
                m_bundle <= NOP_BUNDLE;
                m_pc     <= pc_seq_in;
                m_valid  <= 1'b0;
            end else if (!m_hazard()) begin
                m_instr  <= instruction_in;
                m_bundle <= bundle_in;
                m_pc     <= pc_seq_in;
                m_valid  <= 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (check_en) begin
            bit hz;
            bit issue;
            hz = m_hazard();
            issue = m_valid && !hz;
            chk("stall", 32'(stall_out), 32'(hz));
            chk("instr", instruction_out, issue ? m_instr : NOP_INSTR);
            chk("bundle", 32'(bundle_out), 32'(issue ? m_bundle : NOP_BUNDLE));
            chk("pc_seq", pc_seq_out, m_pc);
            chk("valid", 32'(valid_out), 32'(issue));
            chk("rs", 32'(rs_out), 32'(m_instr[25:21]));
            chk("rt", 32'(rt_out), 32'(m_instr[20:16]));
            chk("rd", 32'(rd_out), 32'(m_instr[15:11]));
            chk("rs_data", rs_data_out, m_read(m_instr[25:21]));
            chk("rt_data", rt_data_out, m_read(m_instr[20:16]));
            chk("imm", imm_ext_out, m_imm(m_instr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] ops [8] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};

    initial begin
        reset = 1'b1;
        instruction_in = '0; bundle_in = '0; pc_seq_in = '0;
        jump_branch_in = 0; wb_en_in = 0; wb_addr_in = '0; wb_data_in = '0;
        ex_mem_read_in = 0; ex_rt_in = '0;
        #1 check_en = 1'b1;
        chk("rst_instr", instruction_out, 32'h34000000);
        chk("rst_pc", pc_seq_out, 32'h00400000);
        tick(); tick();
        reset = 1'b0;

        instruction_in = 32'h34018001; pc_seq_in = 32'h00400004; bundle_in = 24'hABCDEF;
        tick();
        chk("ori_instr", instruction_out, 32'h34018001);
        chk("ori_valid", 32'(valid_out), 32'd1);
        chk("ori_imm", imm_ext_out, 32'h00008001);
        chk("ori_pc", pc_seq_out, 32'h00400004);

        instruction_in = 32'h2001FFF0;
        tick();
        chk("addi_imm", imm_ext_out, 32'hFFFFFFF0);
        instruction_in = 32'h3C011234;
        tick();
        chk("lui_imm", imm_ext_out, 32'h12340000);

        instruction_in = 32'h00A01820;
        tick();
        wb_en_in = 1; wb_addr_in = 5'd5; wb_data_in = 32'hDEADBEEF;
        #1;
`ifdef DECODE_BYPASS_EN
        chk("wr5_same", rs_data_out, 32'hDEADBEEF);
`else
        chk("wr5_same", rs_data_out, 32'h0);
`endif
        tick();
        wb_en_in = 0;
        chk("wr5_next", rs_data_out, 32'hDEADBEEF);

        instruction_in = 32'h00001820;
        wb_en_in = 1; wb_addr_in = 5'd0; wb_data_in = 32'hFFFFFFFF;
        tick();
        wb_en_in = 0;
        chk("wr0", rs_data_out, 32'h0);

        instruction_in = 32'h00441820; pc_seq_in = 32'h00400100;
        tick();
        ex_mem_read_in = 1; ex_rt_in = 5'd4;
        instruction_in = 32'h34018001; pc_seq_in = 32'h00400200;
        #1;
        chk("lu_stall", 32'(stall_out), 32'd1);
        chk("lu_bubble", instruction_out, 32'h34000000);
        chk("lu_valid", 32'(valid_out), 32'd0);
        tick();
        chk("lu_hold_rs", 32'(rs_out), 32'd2);
        chk("lu_hold_rt", 32'(rt_out), 32'd4);
        chk("lu_hold_pc", pc_seq_out, 32'h00400100);
        ex_mem_read_in = 0;
        #1;
        chk("lu_issue", instruction_out, 32'h00441820);
        chk("lu_issue_v", 32'(valid_out), 32'd1);
        tick();

        instruction_in = 32'h00441820; pc_seq_in = 32'h00400300;
        tick();
        ex_mem_read_in = 1; ex_rt_in = 5'd2; jump_branch_in = 1; pc_seq_in = 32'h00400400;
        #1;
        chk("fl_stall", 32'(stall_out), 32'd1);
        tick();
        jump_branch_in = 0; ex_mem_read_in = 0;
        chk("fl_instr", instruction_out, 32'h34000000);
        chk("fl_valid", 32'(valid_out), 32'd0);
        chk("fl_pc", pc_seq_out, 32'h00400400);

        instruction_in = 32'h00441820;
        tick();
        ex_mem_read_in = 1; ex_rt_in = 5'd2;
        #1;
        chk("rs_stall", 32'(stall_out), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("ar_instr", instruction_out, 32'h34000000);
        chk("ar_bundle", 32'(bundle_out), 32'h0E2531);
        chk("ar_pc", pc_seq_out, 32'h00400000);
        chk("ar_valid", 32'(valid_out), 32'd0);
        chk("ar_stall", 32'(stall_out), 32'd0);
        chk("ar_fields", {17'd0, rs_out, rt_out, rd_out}, 32'd0);
        chk("ar_data", rs_data_out | rt_data_out, 32'd0);
        chk("ar_imm", imm_ext_out, 32'd0);
        tick();
        reset = 1'b0; ex_mem_read_in = 0;

        for (int n = 0; n < 3000; n++) begin
            tick();
            instruction_in = {ops[$urandom_range(0, 7)], 5'($urandom_range(0, 7)),
                              5'($urandom_range(0, 7)), 16'($urandom)};
            bundle_in      = 24'($urandom);
            pc_seq_in      = $urandom;
            jump_branch_in = ($urandom_range(0, 7) == 0);
            wb_en_in       = $urandom_range(0, 1) == 1;
            wb_addr_in     = 5'($urandom_range(0, 7));
            wb_data_in     = $urandom;
            ex_mem_read_in = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 2))
                0: ex_rt_in = m_instr[25:21];
                1: ex_rt_in = m_instr[20:16];
                default: ex_rt_in = 5'($urandom_range(0, 7));
            endcase
            if ($urandom_range(0, 199) == 0) begin
                #2 reset = 1'b1;
                #1 reset = 1'b0;
            end
        end
        tick();
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
